ssd_digit_scheduler: RTL and testbench

//  Sequences the two-digit Pmod SSD from the keypad decoder: qualifies each keypress,

---
 rtl/ssd_pkg.sv | 16 +
 rtl/ssd_refresh_timer.sv | 24 ++
 rtl/ssd_digit_scheduler.sv | 125 ++++++++++++
 tb/tb_ssd_digit_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and helpers for the two-digit SSD keypad scheduler.
package ssd_pkg;

  typedef enum logic [1:0] {
    K_IDLE = 2'd0,
    K_QUAL = 2'd1,
    K_HELD = 2'd2
  } key_state_t;

  // Number of clock cycles between chip_sel toggles.
  function automatic int unsigned refresh_div(input int unsigned clk_freq,
                                              input int unsigned refresh_hz);
    return clk_freq / refresh_hz;
  endfunction

endpackage

// File: rtl/ssd_refresh_timer.sv
// Free-running divider: counts 0..DIV-1 and flags the terminal count with a
// one-cycle tick, on which the counter wraps back to 0.
module ssd_refresh_timer #(
  parameter int unsigned DIV = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DIV - 1));

  // Divider counter with wrap at terminal count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/ssd_digit_scheduler.sv
// Qualifies keypad presses, shifts accepted codes into a two-digit register
// and time-multiplexes both digits onto a single display code output.
module ssd_digit_scheduler
  import ssd_pkg::*;
#(
  parameter int unsigned clk_freq      = 125_000_000,
  parameter int unsigned refresh_hz    = 500,
  parameter int unsigned settle_cycles = 1_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_pressed,
  input  logic [3:0] key_code,
  input  logic       clear,
  output logic [3:0] disp_val,
  output logic       chip_sel,
  output logic [3:0] digit_lo,
  output logic [3:0] digit_hi,
  output logic       entry_strobe
);

  localparam int unsigned REFRESH_DIV = refresh_div(clk_freq, refresh_hz);
  localparam int unsigned QW          = $clog2(settle_cycles + 1);

  key_state_t    r_state, w_state_nxt;
  logic [3:0]    r_cand, w_cand_nxt;
  logic [QW-1:0] r_qual, w_qual_nxt;
  logic          w_accept;

  logic [3:0]    r_lo, r_hi;
  logic          r_strobe;
  logic          r_cs, w_cs_nxt;
  logic [3:0]    r_disp;
  logic          w_tick;

  ssd_refresh_timer #(.DIV(REFRESH_DIV)) u_refresh (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_tick (w_tick)
  );

  // Key FSM state, candidate code and qualification counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= K_IDLE;
      r_cand  <= '0;
      r_qual  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_qual  <= w_qual_nxt;
    end
  end

  // Key FSM next state: a code must stay pressed and unchanged for
  // settle_cycles samples; once accepted it is held until release.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_qual_nxt  = r_qual;
    w_accept    = 1'b0;
    case (r_state)
      K_IDLE: begin
        if (key_pressed) begin
          w_cand_nxt  = key_code;
          w_qual_nxt  = '0;
          w_state_nxt = K_QUAL;
        end
      end
      K_QUAL: begin
        if (!key_pressed || (key_code != r_cand)) begin
          w_state_nxt = K_IDLE;
        end else if (r_qual == QW'(settle_cycles - 1)) begin
          w_accept    = 1'b1;
          w_state_nxt = K_HELD;
        end else begin
          w_qual_nxt  = r_qual + QW'(1);
        end
      end
      K_HELD: begin
        if (!key_pressed) w_state_nxt = K_IDLE;
      end
      default: w_state_nxt = K_IDLE;
    endcase
  end

  // Digit shift register and entry strobe; clear overrides a coincident accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo     <= '0;
      r_hi     <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_accept & ~clear;
      if (clear) begin
        r_lo <= '0;
        r_hi <= '0;
      end else if (w_accept) begin
        r_hi <= r_lo;
        r_lo <= r_cand;
      end
    end
  end

  // Display mux selects on the upcoming chip_sel so code and select change together.
  assign w_cs_nxt = r_cs ^ w_tick;

  // Registered chip select and display code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs   <= 1'b0;
      r_disp <= '0;
    end else begin
      r_cs   <= w_cs_nxt;
      r_disp <= w_cs_nxt ? r_hi : r_lo;
    end
  end

  assign disp_val     = r_disp;
  assign chip_sel     = r_cs;
  assign digit_lo     = r_lo;
  assign digit_hi     = r_hi;
  assign entry_strobe = r_strobe;

endmodule

// File: tb/tb_ssd_digit_scheduler.sv
// Directed table-driven bench for ssd_digit_scheduler (REFRESH_DIV=5, settle=4).
module tb_ssd_digit_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_pressed = 1'b0;
  logic [3:0] key_code = '0;
  logic       clear = 1'b0;
  logic [3:0] disp_val;
  logic       chip_sel;
  logic [3:0] digit_lo;
  logic [3:0] digit_hi;
  logic       entry_strobe;

  ssd_digit_scheduler #(
    .clk_freq      (1000),
    .refresh_hz    (200),
    .settle_cycles (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_pressed  (key_pressed),
    .key_code     (key_code),
    .clear        (clear),
    .disp_val     (disp_val),
    .chip_sel     (chip_sel),
    .digit_lo     (digit_lo),
    .digit_hi     (digit_hi),
    .entry_strobe (entry_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kp;
    logic [3:0] code;
    logic       clr;
    logic       stb;
    logic [3:0] lo;
    logic [3:0] hi;
  } vec_t;

  vec_t        vq[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned e        = 0;   // edges since reset release
  logic [3:0]  lo_prev  = '0;
  logic [3:0]  hi_prev  = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e, act, exp);
    end
  endtask

  task automatic add(input int n, input logic kp, input logic [3:0] code, input logic clr,
                     input logic stb, input logic [3:0] lo, input logic [3:0] hi);
    vec_t v;
    v.kp = kp; v.code = code; v.clr = clr; v.stb = stb; v.lo = lo; v.hi = hi;
    repeat (n) vq.push_back(v);
  endtask

  // Apply one vector, clock once, then compare all outputs.
  task automatic step(input vec_t v);
    logic       exp_cs;
    logic [3:0] exp_disp;
    key_pressed = v.kp;
    key_code    = v.code;
    clear       = v.clr;
    @(posedge clk);
    #1;
    e++;
    exp_cs   = ((e / 5) % 2) == 1;
    exp_disp = exp_cs ? hi_prev : lo_prev;
    chk("entry_strobe", int'(entry_strobe), int'(v.stb));
    chk("digit_lo",     int'(digit_lo),     int'(v.lo));
    chk("digit_hi",     int'(digit_hi),     int'(v.hi));
    chk("chip_sel",     int'(chip_sel),     int'(exp_cs));
    chk("disp_val",     int'(disp_val),     int'(exp_disp));
    lo_prev = v.lo;
    hi_prev = v.hi;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " disp_val"},     int'(disp_val),     0);
    chk({tag, " chip_sel"},     int'(chip_sel),     0);
    chk({tag, " digit_lo"},     int'(digit_lo),     0);
    chk({tag, " digit_hi"},     int'(digit_hi),     0);
    chk({tag, " entry_strobe"}, int'(entry_strobe), 0);
  endtask

  initial begin
    // idle: chip_sel toggles every 5 edges, display stays 0
    add(20, 0, 4'h0, 0, 0, 4'h0, 4'h0);
    // key 7 held 10 cycles: strobe on 5th sample edge
    add(4, 1, 4'h7, 0, 0, 4'h0, 4'h0);
    add(1, 1, 4'h7, 0, 1, 4'h7, 4'h0);
    add(5, 1, 4'h7, 0, 0, 4'h7, 4'h0);
    add(3, 0, 4'h0, 0, 0, 4'h7, 4'h0);
    // key 3 then key 9, each held 8 / released 3
    add(4, 1, 4'h3, 0, 0, 4'h7, 4'h0);
    add(1, 1, 4'h3, 0, 1, 4'h3, 4'h7);
    add(3, 1, 4'h3, 0, 0, 4'h3, 4'h7);
    add(3, 0, 4'h0, 0, 0, 4'h3, 4'h7);
    add(4, 1, 4'h9, 0, 0, 4'h3, 4'h7);
    add(1, 1, 4'h9, 0, 1, 4'h9, 4'h3);
    add(3, 1, 4'h9, 0, 0, 4'h9, 4'h3);
    add(3, 0, 4'h0, 0, 0, 4'h9, 4'h3);
    // too-short press, then code change 5->6, then stable 6 accepted
    add(3, 1, 4'h2, 0, 0, 4'h9, 4'h3);
    add(1, 0, 4'h0, 0, 0, 4'h9, 4'h3);
    add(2, 1, 4'h5, 0, 0, 4'h9, 4'h3);
    add(5, 1, 4'h6, 0, 0, 4'h9, 4'h3);
    add(1, 1, 4'h6, 0, 1, 4'h6, 4'h9);
    add(1, 1, 4'h6, 0, 0, 4'h6, 4'h9);
    add(2, 0, 4'h0, 0, 0, 4'h6, 4'h9);
    // clear on the accept edge of A: press consumed, no re-entry while held
    add(4, 1, 4'hA, 0, 0, 4'h6, 4'h9);
    add(1, 1, 4'hA, 1, 0, 4'h0, 4'h0);
    add(4, 1, 4'hA, 0, 0, 4'h0, 4'h0);
    add(2, 0, 4'h0, 0, 0, 4'h0, 4'h0);
    add(4, 1, 4'hA, 0, 0, 4'h0, 4'h0);
    add(1, 1, 4'hA, 0, 1, 4'hA, 4'h0);
    add(2, 0, 4'h0, 0, 0, 4'hA, 4'h0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) step(vq[i]);

    // async reset while qualifying and mid-refresh
    begin
      vec_t v;
      v.kp = 1; v.code = 4'h3; v.clr = 0; v.stb = 0; v.lo = 4'hA; v.hi = 4'h0;
      step(v);
      step(v);
    end
    #2;
    rst = 1'b1;
    #1;
    check_zero("async rst");
    key_pressed = 1'b0;
    key_code    = '0;
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    e       = 0;
    lo_prev = '0;
    hi_prev = '0;
    begin
      vec_t z;
      z.kp = 0; z.code = 4'h0; z.clr = 0; z.stb = 0; z.lo = 4'h0; z.hi = 4'h0;
      for (int i = 0; i < 7; i++) step(z);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
